mem_io_responder: RTL

- Memory-side responder for the CPU's byte-serial memory bus: takes addr/wr/wdata from the memory controller and returns rdata one clock later.
- Contains a byte-addressed synchronous RAM.
- Contains a memory-mapped I/O window with TX and RX byte FIFOs toward a UART-style serial port.
- Sits between the memory controller and external I/O; it is the only target on the bus.

---
 rtl/mem_io_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// Memory-side bus responder: byte RAM plus an I/O window with TX/RX byte FIFOs.
// Optional cycle counter/shadow at offsets 0x8-0xB enabled by MEM_IO_CYCLE_COUNTER_EN.
module mem_io_responder #(
   parameter int          RAM_AW  = 17,
   parameter logic [31:0] IO_BASE = 32'h00030000,
   parameter int          FIFO_AW = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_wr,
   input  logic [31:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);
   localparam int DEPTH = 1 << FIFO_AW;

   logic io_hit, ram_hit, acc_edge;
   logic [3:0] io_off;
   logic prev_io_hit_q, prev_io_hit_d, prev_wr_q, prev_wr_d;
   logic [31:0] prev_addr_q, prev_addr_d;
   logic [7:0]  prev_wdata_q, prev_wdata_d;

   assign io_hit  = (addr[31:4] == IO_BASE[31:4]);
   assign ram_hit = !io_hit;
   assign io_off  = addr[3:0];
   // Held transactions repeat every cycle; side effects only on a new one.
   assign acc_edge = io_hit && (!prev_io_hit_q || (addr != prev_addr_q) ||
                                (mem_wr != prev_wr_q) || (wdata != prev_wdata_q));

   // RAM: array and read register left unreset so they map onto block RAM.
   logic [7:0] ram_mem [0:(1<<RAM_AW)-1];
   logic [7:0] ram_dout_q;
   logic [RAM_AW-1:0] ram_idx;
   assign ram_idx = addr[RAM_AW-1:0];

   always_ff @(posedge clk) begin
      if (ram_hit && mem_wr) ram_mem[ram_idx] <= wdata;
      if (ram_hit && !mem_wr) ram_dout_q <= ram_mem[ram_idx];
   end

   // FIFO storage and pointers
   logic [7:0] tx_mem [0:DEPTH-1];
   logic [7:0] rx_mem [0:DEPTH-1];
   logic [FIFO_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [FIFO_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push, tx_push_ok, tx_pop, rx_pop, rx_push_ok, ovf_clr;
   logic tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
   logic rd_sel_ram_q, rd_sel_ram_d;
   logic [7:0] io_rdata_q, io_rdata_d, status;

   assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                     (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
   assign tx_empty = (tx_wr_q == tx_rd_q);
   assign rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                     (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);
   assign rx_empty = (rx_wr_q == rx_rd_q);

   assign tx_pop     = !tx_empty && tx_ready;
   assign tx_push    = acc_edge && mem_wr && (io_off == 4'h0);
   assign tx_push_ok = tx_push && (!tx_full || tx_pop);
   assign rx_pop     = acc_edge && !mem_wr && (io_off == 4'h0) && !rx_empty;
   // A full RX FIFO still takes a byte when the CPU pops in the same cycle.
   assign rx_push_ok = rx_valid && (!rx_full || rx_pop);
   assign ovf_clr    = acc_edge && mem_wr && (io_off == 4'h1) && wdata[0];
   assign status     = {4'b0000, rx_ovf_q, tx_ovf_q, tx_full, !rx_empty};

   assign tx_data  = tx_mem[tx_rd_q[FIFO_AW-1:0]];
   assign tx_valid = !tx_empty;
   assign rx_ready = !rx_full;
   assign rdata    = rd_sel_ram_q ? ram_dout_q : io_rdata_q;

   always_ff @(posedge clk) begin
      if (tx_push_ok) tx_mem[tx_wr_q[FIFO_AW-1:0]] <= wdata;
      if (rx_push_ok) rx_mem[rx_wr_q[FIFO_AW-1:0]] <= rx_data;
   end

`ifdef MEM_IO_CYCLE_COUNTER_EN
   logic [31:0] cnt_q, cnt_d, shadow_q, shadow_d;
`endif

   always_comb begin
      prev_io_hit_d = io_hit;
      prev_addr_d   = addr;
      prev_wr_d     = mem_wr;
      prev_wdata_d  = wdata;
      tx_wr_d       = tx_wr_q + {{FIFO_AW{1'b0}}, tx_push_ok};
      tx_rd_d       = tx_rd_q + {{FIFO_AW{1'b0}}, tx_pop};
      rx_wr_d       = rx_wr_q + {{FIFO_AW{1'b0}}, rx_push_ok};
      rx_rd_d       = rx_rd_q + {{FIFO_AW{1'b0}}, rx_pop};
      tx_ovf_d      = tx_ovf_q;
      rx_ovf_d      = rx_ovf_q;
      rd_sel_ram_d  = rd_sel_ram_q;
      io_rdata_d    = io_rdata_q;
`ifdef MEM_IO_CYCLE_COUNTER_EN
      cnt_d    = cnt_q + 32'd1;
      shadow_d = shadow_q;
      if (acc_edge && !mem_wr && (io_off == 4'h8)) shadow_d = cnt_q;
`endif
      if (ovf_clr) begin
         tx_ovf_d = 1'b0;
         rx_ovf_d = 1'b0;
      end
      if (tx_push && !tx_push_ok) tx_ovf_d = 1'b1;
      if (rx_valid && !rx_push_ok) rx_ovf_d = 1'b1;

      // Writes leave rdata untouched; reads pick the source for this cycle.
      if (!mem_wr) begin
         rd_sel_ram_d = ram_hit;
         if (io_hit) begin
            case (io_off)
               4'h0: if (acc_edge) io_rdata_d = rx_empty ? 8'h00 : rx_mem[rx_rd_q[FIFO_AW-1:0]];
               4'h1: io_rdata_d = status;
`ifdef MEM_IO_CYCLE_COUNTER_EN
               4'h8: io_rdata_d = shadow_d[7:0];
               4'h9: io_rdata_d = shadow_q[15:8];
               4'hA: io_rdata_d = shadow_q[23:16];
               4'hB: io_rdata_d = shadow_q[31:24];
`endif
               default: io_rdata_d = 8'h00;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_io_hit_q <= 1'b0;
         prev_addr_q   <= 32'h0;
         prev_wr_q     <= 1'b0;
         prev_wdata_q  <= 8'h00;
         tx_wr_q       <= '0;
         tx_rd_q       <= '0;
         rx_wr_q       <= '0;
         rx_rd_q       <= '0;
         tx_ovf_q      <= 1'b0;
         rx_ovf_q      <= 1'b0;
         rd_sel_ram_q  <= 1'b0;
         io_rdata_q    <= 8'h00;
`ifdef MEM_IO_CYCLE_COUNTER_EN
         cnt_q         <= 32'h0;
         shadow_q      <= 32'h0;
`endif
      end else begin
         prev_io_hit_q <= prev_io_hit_d;
         prev_addr_q   <= prev_addr_d;
         prev_wr_q     <= prev_wr_d;
         prev_wdata_q  <= prev_wdata_d;
         tx_wr_q       <= tx_wr_d;
         tx_rd_q       <= tx_rd_d;
         rx_wr_q       <= rx_wr_d;
         rx_rd_q       <= rx_rd_d;
         tx_ovf_q      <= tx_ovf_d;
         rx_ovf_q      <= rx_ovf_d;
         rd_sel_ram_q  <= rd_sel_ram_d;
         io_rdata_q    <= io_rdata_d;
`ifdef MEM_IO_CYCLE_COUNTER_EN
         cnt_q         <= cnt_d;
         shadow_q      <= shadow_d;
`endif
      end
   end
endmodule
